dds_rom_sched: RTL and testbench
================================

# dds_rom_sched

Multi-channel DDS scheduler that time-shares one synchronous sine ROM (256 x 8, one-cycle registered read) among `N_CH` independent phase accumulators. Per channel it holds a frequency tuning word and a phase offset. A round-robin arbiter issues at most one ROM read per cycle. Each returned sample goes into a per-channel holding register with a valid/ready output handshake. The block sits between the configuration bus and the ROM instance; downstream consumers (DAC formatters, mixers) attach per channel.

## Interface
Parameters:
- `N_CH`, 4, number of channels (2..16)
- `PHASE_W`, 32, phase accumulator / tuning word width (>= `ADDR_W`)
- `ADDR_W`, 8, ROM address width
- `DATA_W`, 8, ROM data width

Ports:
- `clk_i`  in  1  system clock
- `arst_n_i`  in  1  reset: one clock; reset is asynchronous and active-low
- `en_i`  in  `N_CH`  per-channel enable
- `cfg_we_i`  in  1  config write strobe
- `cfg_ch_i`  in  `$clog2(N_CH)`  target channel
- `cfg_ftw_i`  in  `PHASE_W`  frequency tuning word
- `cfg_poff_i`  in  `PHASE_W`  phase offset
- `cfg_clr_i`  in  1  with `cfg_we_i`: zero the target accumulator
- `rom_addr_o`  out  `ADDR_W`  ROM address
- `rom_data_i`  in  `DATA_W`  ROM read data, valid one cycle after address
- `smp_valid_o`  out  `N_CH`  sample valid per channel
- `smp_data_o`  out  `N_CH*DATA_W`  samples; channel k at `[k*DATA_W +: DATA_W]`
- `smp_ready_i`  in  `N_CH`  consumer ready per channel

## Operation
- Per-channel state:
  - `acc` (`PHASE_W`)
  - `ftw`
  - `poff`
  - `pend` (read in flight)
  - `hold` (`DATA_W`)
  - `valid`
- Request k = `en_i[k] & ~pend[k] & (~valid[k] | smp_ready_i[k])`.
- Arbiter is round-robin. Search starts at `last+1` mod `N_CH`, where `last` is the most recently granted channel. With no request, `last` is unchanged.
- Grant to k in cycle t:
  - `rom_addr_o = (acc[k] + poff[k])[PHASE_W-1 -: ADDR_W]`, combinational from registers and grant.
  - `acc[k] <= acc[k] + ftw[k]`, modulo 2^`PHASE_W` (wrap, no saturation).
  - `pend[k] <= 1`.
  - The granted channel index is registered as `rd_ch`, with a one-cycle `rd_vld`.
- Cycle t+1, when `rd_vld` is set:
  - `hold[rd_ch] <= rom_data_i`
  - `valid[rd_ch] <= 1`
  - `pend[rd_ch] <= 0`
- Output handshake: when `valid[k] & smp_ready_i[k]`, `valid[k] <= 0`, unless new data lands in the same cycle, in which case `valid` stays 1 with the new data.
- `valid` and `hold` are stable while `~smp_ready_i[k]`.
- No grant: `rom_addr_o` holds its last value (registered copy). Its value is don't-care for the ROM.
- Config write, any cycle: `ftw[cfg_ch_i]` and `poff[cfg_ch_i]` load.
  - With `cfg_clr_i`, `acc <= 0`. This overrides a same-cycle accumulate of that channel.
  - A same-cycle grant to that channel uses the old `acc`/`poff` for the address.
  - The new `ftw`/`poff` apply from the next grant.
- Disable (`en_i[k]` low): no new requests. An in-flight read completes and its sample is presented until consumed. `acc` is retained.

## Timing
- Reset (async assert, sync-safe deassert inside the block). All of the following are 0:
  - `acc`, `ftw`, `poff`, `hold`, `valid`, `pend`, `rd_vld`, `rom_addr_o`
  - `smp_valid_o`, `smp_data_o`
  - `last = N_CH-1`, so channel 0 has first priority.
- Latency, grant to valid: grant in t, ROM data in t+1, `smp_valid_o[k]` high in t+2.
- Throughput:
  - ROM: one read per cycle, aggregate.
  - Per channel: at most one sample per 2 cycles, because `pend` blocks the re-request.
- With N requesters continuously requesting, each is granted exactly once per N cycles.
- Reset mid-read: in-flight data is discarded and no valid appears after deassert.

## Test plan
- Single channel: ch0 `ftw=0x0100_0000`, `poff=0`, `ready=1`. Required:
  - `rom_addr_o` = 0,1,2,…,255,0 on successive grants, one grant per 2 cycles.
  - Samples equal the ROM model.
- Phase offset and wrap: `poff=0x8000_0000`, `ftw=0xFF00_0000`. Required: addresses 128,127,126,…
- Round-robin: all 4 channels enabled, `ready=1`. Required:
  - Grants 0,1,2,3,0,… with one ROM read per cycle.
  - Each channel's valid pulses every 4 cycles.
- Backpressure: ch1 `ready=0` for 10 cycles. Required:
  - ch1 valid held with a stable sample; no further ch1 grant or `acc` advance.
  - Other channels continue.
  - On ready, ch1 is granted within 4 cycles.
- Config collisions:
  - `cfg_we_i` with `cfg_clr_i` on ch2 in its grant cycle: the address uses the old phase and the next ch2 address is 0.
  - Disable ch3 with a read in flight: the sample is delivered and no further ch3 grants occur.
- Reset: assert `arst_n_i` mid-stream. Required: all outputs 0 immediately; after release, the first grant goes to channel 0 at address 0.

Source files
------------

// File: rtl/dds_rom_sched.sv
// Multi-channel DDS scheduler: N_CH phase accumulators share one synchronous sine ROM via a round-robin arbiter.
// Latency: grant in cycle t, ROM data in t+1, smp_valid_o[k] high in t+2; at most one ROM read per cycle.
// Backpressure: a channel with an unconsumed sample (valid & ~ready) or a read in flight stops requesting; others continue.
//
// Ports:
//   clk_i, arst_n_i            clock, asynchronous active-low reset (deassertion synchronised internally)
//   en_i[N_CH]                 per-channel enable
//   cfg_we_i/cfg_ch_i          config write strobe / target channel
//   cfg_ftw_i/cfg_poff_i       tuning word / phase offset loaded on write
//   cfg_clr_i                  with cfg_we_i: zero the target accumulator
//   rom_addr_o/rom_data_i      ROM address (registered hold when idle) / read data one cycle later
//   smp_valid_o/smp_data_o     per-channel sample valid / packed samples (channel k at [k*DATA_W +: DATA_W])
//   smp_ready_i                per-channel consumer ready
module dds_rom_sched #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic [N_CH-1:0]            en_i,
    input  logic                       cfg_we_i,
    input  logic [$clog2(N_CH)-1:0]    cfg_ch_i,
    input  logic [PHASE_W-1:0]         cfg_ftw_i,
    input  logic [PHASE_W-1:0]         cfg_poff_i,
    input  logic                       cfg_clr_i,
    output logic [ADDR_W-1:0]          rom_addr_o,
    input  logic [DATA_W-1:0]          rom_data_i,
    output logic [N_CH-1:0]            smp_valid_o,
    output logic [N_CH*DATA_W-1:0]     smp_data_o,
    input  logic [N_CH-1:0]            smp_ready_i
);
    localparam int CH_W = $clog2(N_CH);

    // Reset asserts asynchronously, releases two clocks after arst_n_i rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [PHASE_W-1:0] acc_q  [N_CH];
    logic [PHASE_W-1:0] ftw_q  [N_CH];
    logic [PHASE_W-1:0] poff_q [N_CH];
    logic [DATA_W-1:0]  hold_q [N_CH];
    logic [N_CH-1:0]    valid_q;
    logic [N_CH-1:0]    pend_q;
    logic [CH_W-1:0]    last_q;
    logic [CH_W-1:0]    rd_ch_q;
    logic               rd_vld_q;
    logic [ADDR_W-1:0]  rom_addr_q;

    logic [N_CH-1:0]    req;
    logic               gnt_vld;
    logic [CH_W-1:0]    gnt_ch;
    logic [CH_W-1:0]    cand;

    // A channel may re-request as soon as its slot will be free at the landing edge.
    always_comb begin
        req = en_i & ~pend_q & (~valid_q | smp_ready_i) & {N_CH{rst_n}};
    end

    // Round-robin: first requester found scanning upward from last_q+1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = last_q;
        cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last_q) + i) % N_CH);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    // Address uses pre-write acc/poff even if a config write hits this channel now.
    always_comb begin
        if (gnt_vld)
            rom_addr_o = ADDR_W'((acc_q[gnt_ch] + poff_q[gnt_ch]) >> (PHASE_W - ADDR_W));
        else
            rom_addr_o = rom_addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_ch_q    <= '0;
            last_q     <= CH_W'(N_CH - 1);
            rom_addr_q <= '0;
        end else begin
            rd_vld_q <= gnt_vld;
            rd_ch_q  <= gnt_ch;
            if (gnt_vld) begin
                last_q     <= gnt_ch;
                rom_addr_q <= rom_addr_o;
            end
        end
    end

    // Accumulate with the old ftw; a same-cycle clear of the channel wins (later assignment).
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_q[k]  <= '0;
                ftw_q[k]  <= '0;
                poff_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (gnt_vld && gnt_ch == CH_W'(k))
                    acc_q[k] <= acc_q[k] + ftw_q[k];
                if (cfg_we_i && cfg_ch_i == CH_W'(k)) begin
                    ftw_q[k]  <= cfg_ftw_i;
                    poff_q[k] <= cfg_poff_i;
                    if (cfg_clr_i)
                        acc_q[k] <= '0;
                end
            end
        end
    end

    // Landing data refreshes the holding register; a consume in the same cycle keeps valid high.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            pend_q  <= '0;
            for (int k = 0; k < N_CH; k++)
                hold_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (rd_vld_q && rd_ch_q == CH_W'(k)) begin
                    hold_q[k]  <= rom_data_i;
                    valid_q[k] <= 1'b1;
                    pend_q[k]  <= 1'b0;
                end else if (valid_q[k] && smp_ready_i[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (gnt_vld && gnt_ch == CH_W'(k))
                    pend_q[k] <= 1'b1;
            end
        end
    end

    always_comb begin
        smp_valid_o = valid_q;
        smp_data_o  = '0;
        for (int k = 0; k < N_CH; k++)
            smp_data_o[k*DATA_W +: DATA_W] = hold_q[k];
    end

endmodule

// File: tb/tb_dds_rom_sched.sv
// Bench for dds_rom_sched: transaction-level reference model with a per-cycle compare process,
// directed scenarios (single channel, wrap, round-robin, backpressure, config collisions, reset)
// followed by randomized enable/ready/config traffic.
module tb_dds_rom_sched;
    localparam int N = 4, PW = 32, AW = 8, DW = 8;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [N-1:0]    en, ready;
    logic            cfg_we, cfg_clr;
    logic [1:0]      cfg_ch;
    logic [PW-1:0]   cfg_ftw, cfg_poff;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    smp_valid;
    logic [N*DW-1:0] smp_data;

    always #5 clk = ~clk;

    dds_rom_sched #(.N_CH(N), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .en_i(en),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_ftw_i(cfg_ftw), .cfg_poff_i(cfg_poff),
        .cfg_clr_i(cfg_clr), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .smp_valid_o(smp_valid), .smp_data_o(smp_data), .smp_ready_i(ready)
    );

    // ROM contents: arbitrary but address-distinct pattern.
    function automatic logic [7:0] rom_val(input logic [7:0] a);
        logic [15:0] t;
        t = {8'd0, a} * 16'd37 + 16'd11;
        return t[7:0] ^ {2'b00, a[7:2]};
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_addr);

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state (value after the most recent clock edge).
    logic [PW-1:0] m_acc [N], m_ftw [N], m_poff [N];
    logic [DW-1:0] m_hold [N];
    bit            m_valid [N], m_pend [N];
    int            m_last, m_rd_ch;
    bit            m_rd_vld;
    logic [AW-1:0] m_rd_addr, m_addr;

    // Grant log produced by the model.
    int            g_ch [$], g_cyc [$];
    logic [AW-1:0] g_addr [$];

    function automatic logic [AW-1:0] phase_addr(input logic [PW-1:0] p);
        return AW'(p >> (PW - AW));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_acc[k] = '0; m_ftw[k] = '0; m_poff[k] = '0; m_hold[k] = '0;
            m_valid[k] = 0; m_pend[k] = 0;
        end
        m_last = N - 1; m_rd_vld = 0; m_rd_ch = 0; m_rd_addr = '0; m_addr = '0;
    endtask

    function automatic int model_grant();
        for (int i = 1; i <= N; i++) begin
            int c = (m_last + i) % N;
            if (en[c] && !m_pend[c] && (!m_valid[c] || ready[c])) return c;
        end
        return -1;
    endfunction

    int            c_g;
    logic [AW-1:0] c_ea;

    always @(negedge clk) begin
        if (!arst_n) begin
            model_reset();
            check("reset_addr", rom_addr, 0);
            check("reset_valid", smp_valid, 0);
            check("reset_data", smp_data, 0);
        end else begin
            c_g  = model_grant();
            c_ea = (c_g >= 0) ? phase_addr(m_acc[c_g] + m_poff[c_g]) : m_addr;
            check("rom_addr", rom_addr, c_ea);
            for (int k = 0; k < N; k++) begin
                check($sformatf("valid%0d", k), smp_valid[k], m_valid[k]);
                if (m_valid[k]) check($sformatf("data%0d", k), smp_data[k*DW +: DW], m_hold[k]);
            end
            if (c_g >= 0) begin
                g_ch.push_back(c_g); g_addr.push_back(c_ea); g_cyc.push_back(cyc);
            end
            for (int k = 0; k < N; k++) begin
                if (m_rd_vld && m_rd_ch == k) begin
                    m_hold[k] = rom_val(m_rd_addr); m_valid[k] = 1; m_pend[k] = 0;
                end else if (m_valid[k] && ready[k]) begin
                    m_valid[k] = 0;
                end
            end
            m_rd_vld = (c_g >= 0);
            if (c_g >= 0) begin
                m_pend[c_g] = 1;
                m_acc[c_g]  = m_acc[c_g] + m_ftw[c_g];
                m_last      = c_g;
                m_addr      = c_ea;
                m_rd_ch     = c_g;
                m_rd_addr   = c_ea;
            end
            if (cfg_we) begin
                m_ftw[cfg_ch]  = cfg_ftw;
                m_poff[cfg_ch] = cfg_poff;
                if (cfg_clr) m_acc[cfg_ch] = '0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic [PW-1:0] f, input logic [PW-1:0] p, input bit clr);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_ftw = f; cfg_poff = p; cfg_clr = clr;
        tick();
        cfg_we = 0; cfg_clr = 0;
    endtask

    task automatic wait_grants(input string nm, input int s, input int n, input int budget);
        int b = 0;
        while (g_ch.size() < s + n && b < budget) begin
            tick(); b++;
        end
        check(nm, (g_ch.size() >= s + n), 1);
    endtask

    int s, st, rel, col, cnt, first;
    bit found;
    logic [AW-1:0] old_addr;

    initial begin
        arst_n = 0; en = '0; ready = '0; cfg_we = 0; cfg_clr = 0;
        cfg_ch = '0; cfg_ftw = '0; cfg_poff = '0;
        repeat (3) tick();
        check("init_addr", rom_addr, 0);
        check("init_valid", smp_valid, 0);
        check("init_data", smp_data, 0);
        arst_n = 1;
        repeat (4) tick();

        // Single channel sweep: addresses 0..255,0 at one grant per two cycles.
        ready = '1;
        cfg_write(0, 32'h0100_0000, 32'h0, 0);
        s = g_ch.size(); en = 4'b0001;
        wait_grants("s1_grants", s, 257, 600);
        en = '0;
        for (int j = 0; j < 257; j++) begin
            if (s + j < g_ch.size()) begin
                check("s1_ch", g_ch[s+j], 0);
                check("s1_addr", g_addr[s+j], j % 256);
                if (j > 0) check("s1_spacing", g_cyc[s+j] - g_cyc[s+j-1], 2);
            end
        end
        repeat (4) tick();

        // Phase offset and descending wrap.
        cfg_write(0, 32'hFF00_0000, 32'h8000_0000, 1);
        s = g_ch.size(); en = 4'b0001;
        wait_grants("s2_grants", s, 3, 20);
        en = '0;
        if (g_ch.size() >= s + 3) begin
            check("s2_addr0", g_addr[s], 128);
            check("s2_addr1", g_addr[s+1], 127);
            check("s2_addr2", g_addr[s+2], 126);
        end
        repeat (4) tick();

        // Round-robin with all channels: ch0 was last, so rotation starts at ch1.
        cfg_write(1, 32'h0300_0000, 32'h1000_0000, 0);
        cfg_write(2, 32'h0500_0000, 32'h4000_0000, 0);
        cfg_write(3, 32'h0700_0000, 32'h2000_0000, 0);
        s = g_ch.size(); en = '1;
        wait_grants("s3_grants", s, 20, 40);
        for (int j = 0; j < 20; j++) begin
            if (s + j < g_ch.size()) begin
                check("s3_rr_ch", g_ch[s+j], (j + 1) % 4);
                check("s3_rr_cycle", g_cyc[s+j] - g_cyc[s], j);
            end
        end

        // Backpressure on ch1 for 10 cycles.
        ready = 4'b1101; st = cyc; s = g_ch.size();
        repeat (10) tick();
        check("s4_ch1_valid_held", smp_valid[1], 1);
        cnt = 0;
        for (int j = s; j < g_ch.size(); j++) if (g_ch[j] == 1 && g_cyc[j] >= st + 2) cnt++;
        check("s4_no_ch1_grant", cnt, 0);
        cnt = 0;
        for (int j = s; j < g_ch.size(); j++) if (g_ch[j] != 1) cnt++;
        check("s4_others_continue", (cnt >= 6), 1);
        ready = '1; rel = cyc; s = g_ch.size();
        repeat (6) tick();
        first = -1;
        for (int j = s; j < g_ch.size(); j++) if (g_ch[j] == 1 && first < 0) first = g_cyc[j] - rel;
        check("s4_regrant_within_4", (first >= 0 && first <= 3), 1);

        // Clear on ch2 in the very cycle ch2 is granted.
        found = 0;
        for (int b = 0; b < 10 && !found; b++) begin
            if (model_grant() == 2) found = 1;
            else tick();
        end
        check("s5_found_ch2_slot", found, 1);
        old_addr = phase_addr(m_acc[2] + m_poff[2]);
        cfg_we = 1; cfg_ch = 2'd2; cfg_ftw = 32'h0500_0000; cfg_poff = 32'h0; cfg_clr = 1;
        col = cyc; s = g_ch.size();
        tick();
        cfg_we = 0; cfg_clr = 0;
        for (int b = 0; b < 20; b++) begin
            cnt = 0;
            for (int j = s; j < g_ch.size(); j++) if (g_ch[j] == 2) cnt++;
            if (cnt < 2) tick();
        end
        cnt = 0;
        for (int j = s; j < g_ch.size(); j++) begin
            if (g_ch[j] == 2) begin
                if (cnt == 0) begin
                    check("s5_collide_cycle", g_cyc[j], col);
                    check("s5_old_phase_addr", g_addr[j], old_addr);
                end else if (cnt == 1) begin
                    check("s5_next_addr_zero", g_addr[j], 0);
                end
                cnt++;
            end
        end
        check("s5_two_ch2_grants", (cnt >= 2), 1);

        // Disable ch3 while its read is in flight.
        found = 0;
        for (int b = 0; b < 10 && !found; b++) begin
            if (m_pend[3]) found = 1;
            else tick();
        end
        check("s6_found_inflight", found, 1);
        en = 4'b0111; st = cyc;
        tick();
        check("s6_sample_delivered", smp_valid[3], 1);
        repeat (10) tick();
        cnt = 0;
        for (int j = 0; j < g_ch.size(); j++) if (g_ch[j] == 3 && g_cyc[j] >= st) cnt++;
        check("s6_no_ch3_grant", cnt, 0);

        // Reset in the middle of traffic.
        en = '1;
        repeat (3) tick();
        arst_n = 0; en = '0;
        #1;
        check("s7_addr_zero", rom_addr, 0);
        check("s7_valid_zero", smp_valid, 0);
        check("s7_data_zero", smp_data, 0);
        repeat (2) tick();
        arst_n = 1;
        repeat (4) tick();
        s = g_ch.size(); en = '1;
        tick();
        check("s7_grant_after_reset", (g_ch.size() > s), 1);
        if (g_ch.size() > s) begin
            check("s7_first_ch", g_ch[s], 0);
            check("s7_first_addr", g_addr[s], 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            en      = 4'($urandom);
            ready   = 4'($urandom);
            cfg_we  = ($urandom_range(3) == 0);
            cfg_ch  = 2'($urandom);
            cfg_ftw = $urandom;
            cfg_poff = $urandom;
            cfg_clr = ($urandom_range(2) == 0);
            tick();
        end
        en = '0; cfg_we = 0; cfg_clr = 0; ready = '1;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
